move_entry: RTL and testbench

MOVE_ENTRY -- requirements
Module: move_entry

---
 rtl/move_entry_pkg.sv | 58 +++++
 rtl/move_entry_debounce.sv | 43 ++++
 rtl/move_entry.sv | 84 ++++++++
 tb/tb_move_entry.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_entry_pkg.sv
// Shared codes for the cursor/move-entry block and the board stage.
// Also holds the cursor stepping and cell index helpers.
package move_entry_pkg;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    X_WIN   = 2'b01,
    O_WIN   = 2'b10,
    DRAW    = 2'b11
  } game_state_t;

  typedef enum logic [1:0] {
    ROW1 = 2'b01,
    ROW2 = 2'b10,
    ROW3 = 2'b11
  } row_t;

  typedef enum logic [1:0] {
    COL1 = 2'b01,
    COL2 = 2'b10,
    COL3 = 2'b11
  } col_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic place;
  } btn_ev_t;

  // Opposing steps in the same cycle cancel.
  function automatic logic [1:0] step3(
    input logic [1:0] c,
    input logic       dec,
    input logic       inc
  );
    logic [1:0] r;
    r = c;
    if (dec && !inc)
      r = (c == 2'b01) ? 2'b11 : c - 2'd1;
    else if (inc && !dec)
      r = (c == 2'b11) ? 2'b01 : c + 2'd1;
    return r;
  endfunction

  function automatic logic [3:0] cell_idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] rr;
    logic [3:0] cc;
    rr = {2'b00, r - 2'd1};
    cc = {2'b00, c - 2'd1};
    return (rr << 1) + rr + cc;
  endfunction

endpackage

// File: rtl/move_entry_debounce.sv
// Two-flop synchroniser, stability counter and press pulse
// for a single raw push button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          level;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      pulse <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      pulse <= 1'b0;
      if (sync1 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        level <= sync1;
        count <= '0;
        pulse <= sync1;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/move_entry.sv
// Cursor movement and place-request front end: debounced buttons
// steer a 3x3 cursor and raise set/reject strobes to the board.
module move_entry
  import move_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [8:0] valid,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       reject,
  output logic [3:0] cursor_idx
);

  logic [4:0] raw;
  logic [4:0] ev;
  btn_ev_t    e;

  assign raw = {btn_up, btn_down, btn_left, btn_right, btn_place};
  assign e   = btn_ev_t'(ev);

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .pulse (ev[i])
    );
  end

  // Moves that coincide with a place are held back one cycle so
  // the outputs keep showing the cell that was placed on.
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [1:0] row_mid;
  logic [1:0] col_mid;
  logic [1:0] row_nxt;
  logic [1:0] col_nxt;
  logic       ok;

  always_comb begin
    row_mid  = step3(row, pend[3], pend[2]);
    col_mid  = step3(col, pend[1], pend[0]);
    row_nxt  = step3(row_mid, e.up, e.down);
    col_nxt  = step3(col_mid, e.left, e.right);
    pend_nxt = 4'b0000;
    ok       = !valid[cursor_idx] && (game_state == PLAYING);
    if (e.place) begin
      row_nxt  = row;
      col_nxt  = col;
      pend_nxt = {e.up, e.down, e.left, e.right};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= ROW2;
      col        <= COL2;
      cursor_idx <= 4'd4;
      pend       <= 4'b0000;
      set        <= 1'b0;
      reject     <= 1'b0;
    end else begin
      row        <= row_nxt;
      col        <= col_nxt;
      cursor_idx <= cell_idx(row_nxt, col_nxt);
      pend       <= pend_nxt;
      set        <= e.place && ok;
      reject     <= e.place && !ok;
    end
  end

endmodule

// File: tb/tb_move_entry.sv
// Self-checking bench for move_entry: directed scenarios plus random
// button traffic against a queue-based behavioural model.
module tb_move_entry;
  import move_entry_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_place = 1'b0;
  logic [8:0] valid = '0;
  logic [1:0] game_state = 2'b00;
  logic [1:0] row;
  logic [1:0] col;
  logic       set;
  logic       reject;
  logic [3:0] cursor_idx;

  move_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_place  (btn_place),
    .valid      (valid),
    .game_state (game_state),
    .row        (row),
    .col        (col),
    .set        (set),
    .reject     (reject),
    .cursor_idx (cursor_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;

  // Model: buttons 0..4 = up, down, left, right, place.
  bit         q1 [5];
  bit         q2 [5];
  bit         lvl [5];
  bit         ev [5];
  bit         hist [5][$];
  int         m_row = 2;
  int         m_col = 2;
  int         pend_dr = 0;
  int         pend_dc = 0;
  bit         m_set = 0;
  bit         m_rej = 0;
  logic [10:0] expv;
  wire  [10:0] obs = {row, col, cursor_idx, set, reject};

  function automatic int wrap3(input int v);
    return (((v - 1) % 3) + 3) % 3 + 1;
  endfunction

  always @(posedge clk) begin
    bit raw [5];
    bit s;
    bit all;
    int dr;
    int dc;
    raw = '{btn_up, btn_down, btn_left, btn_right, btn_place};
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        q1[b] = 0; q2[b] = 0; lvl[b] = 0; ev[b] = 0;
        hist[b].delete();
      end
      m_row = 2; m_col = 2; pend_dr = 0; pend_dc = 0;
      m_set = 0; m_rej = 0;
    end else begin
      dr = int'(ev[1]) - int'(ev[0]);
      dc = int'(ev[3]) - int'(ev[2]);
      m_set = 0;
      m_rej = 0;
      if (ev[4]) begin
        if (!valid[3*(m_row-1)+(m_col-1)] && game_state == 2'b00)
          m_set = 1;
        else
          m_rej = 1;
        pend_dr = dr;
        pend_dc = dc;
      end else begin
        m_row = wrap3(m_row + pend_dr + dr);
        m_col = wrap3(m_col + pend_dc + dc);
        pend_dr = 0;
        pend_dc = 0;
      end
      for (int b = 0; b < 5; b++) begin
        s = q2[b];
        q2[b] = q1[b];
        q1[b] = raw[b];
        hist[b].push_back(s);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        all = (hist[b].size() == D);
        foreach (hist[b][j]) if (hist[b][j] == lvl[b]) all = 0;
        ev[b] = 0;
        if (all) begin
          lvl[b] = !lvl[b];
          hist[b].delete();
          ev[b] = lvl[b];
        end
      end
    end
    expv = {2'(m_row), 2'(m_col), 4'(3*(m_row-1)+(m_col-1)), m_set, m_rej};
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_model t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    vectors++;
    if (row !== ROW2 || col !== COL2 || cursor_idx !== 4'd4 || set || reject) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, 11'b10_10_0100_0_0);
    end
    reset = 1'b0;
  endtask

  task automatic test_right_wrap();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 18; c++) begin
        btn_right = (c < 10);
        @(negedge clk);
        vectors++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL right_wrap t=%0t got=%h exp=%h", $time, obs, expv);
        end
      end
      vectors++;
      if (p == 0 && (col !== COL3 || cursor_idx !== 4'd5)) begin
        errors++;
        $display("FAIL right_once col=%b idx=%0d exp col=11 idx=5", col, cursor_idx);
      end
      if (p == 1 && (col !== COL1 || cursor_idx !== 4'd3)) begin
        errors++;
        $display("FAIL right_wrap col=%b idx=%0d exp col=01 idx=3", col, cursor_idx);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 30; c++) begin
      btn_up = (c < 20) ? ((c / 2) % 2 == 0) : 1'b0;
      @(negedge clk);
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL bounce t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    vectors++;
    if (row !== ROW2) begin
      errors++;
      $display("FAIL bounce_row got=%b exp=10", row);
    end
  endtask

  task automatic test_place(input logic [8:0] v, input logic [1:0] gs,
                            input int exp_set, input int exp_rej);
    int ns;
    int nr;
    ns = 0;
    nr = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    valid = v;
    game_state = gs;
    for (int c = 0; c < 16; c++) begin
      btn_place = (c < 10);
      @(negedge clk);
      if (set) ns++;
      if (reject) nr++;
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL place t=%0t got=%h exp=%h", $time, obs, expv);
      end
      if (set && (row !== ROW2 || col !== COL2)) begin
        errors++;
        $display("FAIL place_cell row=%b col=%b exp 10/10", row, col);
      end
    end
    vectors++;
    if (ns != exp_set || nr != exp_rej) begin
      errors++;
      $display("FAIL place_count set=%0d rej=%0d exp set=%0d rej=%0d",
               ns, nr, exp_set, exp_rej);
    end
    valid = '0;
    game_state = 2'b00;
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 14; c++) begin
        btn_up = (c < 9);
        btn_down = (p == 0) && (c < 9);
        btn_left = (p == 1) && (c < 9);
        @(negedge clk);
        vectors++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL simul t=%0t got=%h exp=%h", $time, obs, expv);
        end
      end
      vectors++;
      if (p == 0 && row !== ROW2) begin
        errors++;
        $display("FAIL up_down row=%b exp=10", row);
      end
      if (p == 1 && (row !== ROW1 || col !== COL1 || cursor_idx !== 4'd0)) begin
        errors++;
        $display("FAIL up_left got=%b/%b/%0d exp 01/01/0", row, col, cursor_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ns;
    int at;
    ns = 0;
    at = -1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    btn_right = 1'b1;
    repeat (8) @(negedge clk);
    btn_right = 1'b0;
    btn_place = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (set || reject || row !== ROW2 || col !== COL2) begin
        errors++;
        $display("FAIL reset_mid_hold got=%h exp=%h", obs, 11'b10_10_0100_0_0);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (set) begin ns++; at = c; end
      vectors++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_mid t=%0t got=%h exp=%h", $time, obs, expv);
      end
    end
    vectors++;
    if (ns != 1 || at != D + 3) begin
      errors++;
      $display("FAIL reset_mid_set count=%0d at=%0d exp count=1 at=%0d", ns, at, D + 3);
    end
    btn_place = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 300; seg++) begin
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 3) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 3) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 3) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 3) == 0) btn_place = ~btn_place;
      valid = 9'($urandom);
      game_state = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      reset = ($urandom_range(0, 40) == 0);
      repeat (hold) begin
        @(negedge clk);
        vectors++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random t=%0t got=%h exp=%h", $time, obs, expv);
        end
        if (set && reject) begin
          errors++;
          $display("FAIL strobe_excl set=%b rej=%b exp not both", set, reject);
        end
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_wrap();
    test_bounce();
    test_place(9'h000, 2'b00, 1, 0);
    test_place(9'h010, 2'b00, 0, 1);
    test_place(9'h000, 2'b01, 0, 1);
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
